// File: rtl/gpio_bank.sv
// GPIO bank: register-mapped pad outputs/enables, synchronised pad inputs and
// optional edge interrupts (enabled by defining GPIO_BANK_IRQ_EN).
module gpio_bank #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reg_valid,
   input  logic             reg_we,
   input  logic [2:0]       reg_addr,
   input  logic [31:0]      reg_wdata,
   output logic             reg_ready,
   output logic [31:0]      reg_rdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oeb,
   output logic             irq
);

   localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
   localparam logic [2:0] ADDR_OEB      = 3'd1;
   localparam logic [2:0] ADDR_DATA_IN  = 3'd2;
   localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
   localparam logic [2:0] ADDR_IRQ_EDGE = 3'd4;
   localparam logic [2:0] ADDR_IRQ_PEND = 3'd5;
   localparam logic [2:0] ADDR_OUT_SET  = 3'd6;
   localparam logic [2:0] ADDR_OUT_CLR  = 3'd7;

   logic [WIDTH-1:0] data_out_q;
   logic [WIDTH-1:0] oeb_q;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] wdata_w;
   logic [31:0]      rd_mux;
   logic             access;
   logic             wr_en;
   logic             unused_wdata;

   // A request is only accepted while no completion is showing, which limits
   // the bus to one access every two cycles.
   assign access       = reg_valid & ~reg_ready;
   assign wr_en        = access & reg_we;
   assign wdata_w      = reg_wdata[WIDTH-1:0];
   assign unused_wdata = ^(reg_wdata >> WIDTH);
   assign data_in      = sync_q[SYNC_STAGES-1];
   assign gpio_out     = data_out_q;
   assign gpio_oeb     = oeb_q;

   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      logic [31:0] r;
      r          = '0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // the pre-edge value of its neighbours; blocking here would collapse the
   // synchroniser chain into a single stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // NOTE: every flop here, including the pad enables, has an explicit reset
   // value so the pins come up as inputs before any software runs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_q <= '0;
         oeb_q      <= '1;
      end else if (wr_en) begin
         case (reg_addr)
            ADDR_DATA_OUT: data_out_q <= wdata_w;
            ADDR_OEB:      oeb_q      <= wdata_w;
            ADDR_OUT_SET:  data_out_q <= data_out_q | wdata_w;
            ADDR_OUT_CLR:  data_out_q <= data_out_q & ~wdata_w;
            default:       ;
         endcase
      end
   end

`ifdef GPIO_BANK_IRQ_EN
   logic [WIDTH-1:0] irq_en_q;
   logic [WIDTH-1:0] irq_edge_q;
   logic [WIDTH-1:0] irq_pend_q;
   logic [WIDTH-1:0] edge_prev_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_event;
   logic [WIDTH-1:0] pend_clr;

   // Events come only from pin data, so rewriting IRQ_EDGE never fires one.
   assign rise       = data_in & ~edge_prev_q;
   assign fall       = ~data_in & edge_prev_q;
   assign edge_event = (rise & irq_edge_q) | (fall & ~irq_edge_q);
   assign pend_clr   = (wr_en && reg_addr == ADDR_IRQ_PEND) ? wdata_w : '0;
   assign irq        = |(irq_pend_q & irq_en_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en_q    <= '0;
         irq_edge_q  <= '0;
         irq_pend_q  <= '0;
         edge_prev_q <= '0;
      end else begin
         edge_prev_q <= data_in;
         if (wr_en && reg_addr == ADDR_IRQ_EN)   irq_en_q   <= wdata_w;
         if (wr_en && reg_addr == ADDR_IRQ_EDGE) irq_edge_q <= wdata_w;
         // The OR is applied after the clear so a coincident edge wins.
         irq_pend_q <= (irq_pend_q & ~pend_clr) | edge_event;
      end
   end
`else
   assign irq = 1'b0;
`endif

   // NOTE: rd_mux gets a default before the case so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      rd_mux = '0;
      case (reg_addr)
         ADDR_DATA_OUT: rd_mux = zext(data_out_q);
         ADDR_OEB:      rd_mux = zext(oeb_q);
         ADDR_DATA_IN:  rd_mux = zext(data_in);
`ifdef GPIO_BANK_IRQ_EN
         ADDR_IRQ_EN:   rd_mux = zext(irq_en_q);
         ADDR_IRQ_EDGE: rd_mux = zext(irq_edge_q);
         ADDR_IRQ_PEND: rd_mux = zext(irq_pend_q);
`endif
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_ready <= 1'b0;
         reg_rdata <= '0;
      end else begin
         reg_ready <= access;
         reg_rdata <= (access && !reg_we) ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: constant vector table, hand-timed corner
// sequences and randomised accesses against a history-based reference model.
module tb_gpio_bank;

   localparam int W = 16;
   localparam int S = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          reg_valid;
   logic          reg_we;
   logic [2:0]    reg_addr;
   logic [31:0]   reg_wdata;
   logic          reg_ready;
   logic [31:0]   reg_rdata;
   logic [W-1:0]  gpio_in;
   logic [W-1:0]  gpio_out;
   logic [W-1:0]  gpio_oeb;
   logic          irq;

   int checks   = 0;
   int failures = 0;

   gpio_bank #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk       (clk),
      .reset     (reset),
      .reg_valid (reg_valid),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_ready (reg_ready),
      .reg_rdata (reg_rdata),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .gpio_oeb  (gpio_oeb),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   // Reference model: pin history gives DATA_IN as the value S samples ago,
   // and edge events as the difference of two consecutive delayed samples.
   logic [W-1:0] hist [0:S];
   logic [W-1:0] m_out, m_oeb, m_en, m_edge, m_pend;
   logic         m_ready;
   logic [31:0]  m_rdata;
   logic         m_irq;

`ifdef GPIO_BANK_IRQ_EN
   assign m_irq = |(m_pend & m_en);
`else
   assign m_irq = 1'b0;
`endif

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= S; i++) hist[i] <= '0;
         m_out   <= '0;
         m_oeb   <= '1;
         m_en    <= '0;
         m_edge  <= '0;
         m_pend  <= '0;
         m_ready <= 1'b0;
         m_rdata <= '0;
      end else begin : model
         logic         acc;
         logic [W-1:0] w, newv, oldv, ev, p;
         logic [31:0]  rd;
         acc  = reg_valid && !m_ready;
         w    = reg_wdata[W-1:0];
         newv = hist[S-1];
         oldv = hist[S];
         ev   = (newv & ~oldv & m_edge) | (~newv & oldv & ~m_edge);
         rd   = 32'h0;
         case (reg_addr)
            3'd0: rd = {16'h0, m_out};
            3'd1: rd = {16'h0, m_oeb};
            3'd2: rd = {16'h0, newv};
`ifdef GPIO_BANK_IRQ_EN
            3'd3: rd = {16'h0, m_en};
            3'd4: rd = {16'h0, m_edge};
            3'd5: rd = {16'h0, m_pend};
`endif
            default: rd = 32'h0;
         endcase
         m_ready <= acc;
         m_rdata <= (acc && !reg_we) ? rd : 32'h0;
         hist[0] <= gpio_in;
         for (int i = 1; i <= S; i++) hist[i] <= hist[i-1];
         if (acc && reg_we) begin
            case (reg_addr)
               3'd0: m_out <= w;
               3'd1: m_oeb <= w;
`ifdef GPIO_BANK_IRQ_EN
               3'd3: m_en   <= w;
               3'd4: m_edge <= w;
`endif
               3'd6: m_out <= m_out | w;
               3'd7: m_out <= m_out & ~w;
               default: ;
            endcase
         end
`ifdef GPIO_BANK_IRQ_EN
         p = m_pend;
         if (acc && reg_we && reg_addr == 3'd5) p = p & ~w;
         m_pend <= p | ev;
`endif
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One access, started at a negedge; ends one idle cycle after completion.
   task automatic access(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata);
      int n;
      reg_valid = 1'b1;
      reg_we    = we;
      reg_addr  = addr;
      reg_wdata = wdata;
      n = 0;
      @(negedge clk);
      while (reg_ready !== 1'b1 && n < 4) begin
         @(negedge clk);
         n++;
      end
      check("reg_ready", {31'h0, reg_ready}, 32'h1);
      rdata = reg_rdata;
      if (!we) check("rdata_model", reg_rdata, m_rdata);
      check("gpio_out_model", {16'h0, gpio_out}, {16'h0, m_out});
      check("gpio_oeb_model", {16'h0, gpio_oeb}, {16'h0, m_oeb});
      check("irq_model", {31'h0, irq}, {31'h0, m_irq});
      reg_valid = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [15:0] exp_out;
      logic [15:0] exp_oeb;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;

      tbl[0]  = '{1'b0, 3'd1, 32'h0,        32'h0000FFFF, 16'h0000, 16'hFFFF};
      tbl[1]  = '{1'b1, 3'd1, 32'h000000FF, 32'h0,        16'h0000, 16'h00FF};
      tbl[2]  = '{1'b1, 3'd0, 32'h0000A500, 32'h0,        16'hA500, 16'h00FF};
      tbl[3]  = '{1'b1, 3'd6, 32'h0000000B, 32'h0,        16'hA50B, 16'h00FF};
      tbl[4]  = '{1'b1, 3'd7, 32'h00000500, 32'h0,        16'hA00B, 16'h00FF};
      tbl[5]  = '{1'b0, 3'd0, 32'h0,        32'h0000A00B, 16'hA00B, 16'h00FF};
      tbl[6]  = '{1'b0, 3'd6, 32'h0,        32'h00000000, 16'hA00B, 16'h00FF};
      tbl[7]  = '{1'b0, 3'd7, 32'h0,        32'h00000000, 16'hA00B, 16'h00FF};
      tbl[8]  = '{1'b1, 3'd0, 32'hFFFF1234, 32'h0,        16'h1234, 16'h00FF};
      tbl[9]  = '{1'b0, 3'd0, 32'h0,        32'h00001234, 16'h1234, 16'h00FF};
      tbl[10] = '{1'b1, 3'd1, 32'hFFFFFFFF, 32'h0,        16'h1234, 16'hFFFF};
      tbl[11] = '{1'b0, 3'd1, 32'h0,        32'h0000FFFF, 16'h1234, 16'hFFFF};

      reset     = 1'b1;
      reg_valid = 1'b0;
      reg_we    = 1'b0;
      reg_addr  = 3'd0;
      reg_wdata = 32'h0;
      gpio_in   = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'h0, reg_ready}, 32'h0);
      check("rst_rdata", reg_rdata, 32'h0);
      check("rst_out", {16'h0, gpio_out}, 32'h0);
      check("rst_oeb", {16'h0, gpio_oeb}, 32'h0000FFFF);
      check("rst_irq", {31'h0, irq}, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         access(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
         if (!tbl[i].we) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
         check($sformatf("tbl%0d_out", i), {16'h0, gpio_out}, {16'h0, tbl[i].exp_out});
         check($sformatf("tbl%0d_oeb", i), {16'h0, gpio_oeb}, {16'h0, tbl[i].exp_oeb});
      end
      check("idle_rdata", reg_rdata, 32'h0);

      // DATA_IN latency: a read sampled S edges after the change still sees
      // the old value, one sampled S+1 edges after sees the new one.
      gpio_in = 16'h1234;
      repeat (S-1) @(negedge clk);
      access(1'b0, 3'd2, 32'h0, rd);
      check("din_before", rd, 32'h0);
      access(1'b0, 3'd2, 32'h0, rd);
      check("din_after", rd, 32'h00001234);
      gpio_in = 16'h5678;
      repeat (S) @(negedge clk);
      access(1'b0, 3'd2, 32'h0, rd);
      check("din_exact", rd, 32'h00005678);
      access(1'b1, 3'd2, 32'hFFFFFFFF, rd);
      access(1'b0, 3'd2, 32'h0, rd);
      check("din_ro", rd, 32'h00005678);
      check("din_ro_out", {16'h0, gpio_out}, 32'h00001234);

`ifdef GPIO_BANK_IRQ_EN
      gpio_in = 16'h0002;
      repeat (S+3) @(negedge clk);
      access(1'b1, 3'd3, 32'h3, rd);
      access(1'b1, 3'd4, 32'h1, rd);
      access(1'b1, 3'd5, 32'hFFFF, rd);
      access(1'b0, 3'd5, 32'h0, rd);
      check("pend_cleared", rd, 32'h0);
      gpio_in = 16'h0001;
      repeat (S+3) @(negedge clk);
      access(1'b0, 3'd5, 32'h0, rd);
      check("pend_both", rd, 32'h3);
      check("irq_both", {31'h0, irq}, 32'h1);
      access(1'b1, 3'd5, 32'h1, rd);
      access(1'b0, 3'd5, 32'h0, rd);
      check("pend_w1c", rd, 32'h2);
      check("irq_w1c", {31'h0, irq}, 32'h1);
      gpio_in = 16'h0000;
      repeat (S+3) @(negedge clk);
      gpio_in = 16'h0001;
      repeat (S) @(negedge clk);
      access(1'b1, 3'd5, 32'h1, rd);
      access(1'b0, 3'd5, 32'h0, rd);
      check("pend_set_wins", rd, 32'h3);
`else
      access(1'b1, 3'd3, 32'hFFFF, rd);
      access(1'b1, 3'd4, 32'hFFFF, rd);
      access(1'b1, 3'd5, 32'hFFFF, rd);
      for (int i = 0; i < 20; i++) begin
         gpio_in = ~gpio_in;
         @(negedge clk);
         check("noirq_irq", {31'h0, irq}, 32'h0);
      end
      for (int a = 3; a <= 5; a++) begin
         access(1'b0, 3'(a), 32'h0, rd);
         check($sformatf("noirq_reg%0d", a), rd, 32'h0);
      end
`endif

      // Reset in the middle of an access must swallow it.
      reg_valid = 1'b1;
      reg_we    = 1'b0;
      reg_addr  = 3'd1;
      #2 reset = 1'b1;
      @(negedge clk);
      check("abort_ready", {31'h0, reg_ready}, 32'h0);
      check("abort_oeb", {16'h0, gpio_oeb}, 32'h0000FFFF);
      reg_valid = 1'b0;
      gpio_in   = '0;
      reset     = 1'b0;
      @(negedge clk);
      access(1'b0, 3'd1, 32'h0, rd);
      check("post_abort_oeb", rd, 32'h0000FFFF);

      for (int i = 0; i < 300; i++) begin
         logic [2:0] a;
         gpio_in = W'($urandom);
         a = 3'($urandom_range(0, 7));
         access(1'($urandom_range(0, 1)), a, $urandom, rd);
         if ($urandom_range(0, 3) == 0) begin
            gpio_in = W'($urandom);
            @(negedge clk);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter WIDTH, default 16, number of GPIO pins; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, depth of the input synchroniser; legal range 2..4.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 reg_valid  input  1  register access request.
REQ-006 reg_we  input  1  1=write, 0=read; qualified by reg_valid.
REQ-007 reg_addr  input  3  word address of the register.
REQ-008 reg_wdata  input  32  write data.
REQ-009 reg_ready  output  1  one-cycle completion pulse.
REQ-010 reg_rdata  output  32  read data; valid only while reg_ready=1, otherwise 0.
REQ-011 gpio_in  input  WIDTH  pad input values; asynchronous to clk.
REQ-012 gpio_out  output  WIDTH  pad output values.
REQ-013 gpio_oeb  output  WIDTH  pad output enables, active-low (1=input).
REQ-014 irq  output  1  level interrupt request.

Function
REQ-015 Register map: 0 DATA_OUT (rw), 1 OEB (rw), 2 DATA_IN (ro), 3 IRQ_EN (rw), 4 IRQ_EDGE (rw; 1=rising, 0=falling), 5 IRQ_PEND (read; write-1-to-clear), 6 OUT_SET (wo; 1 sets DATA_OUT bit), 7 OUT_CLR (wo; 1 clears DATA_OUT bit).
REQ-016 gpio_out shall equal DATA_OUT and gpio_oeb shall equal OEB; both are driven directly from registers with no added latency.
REQ-017 Access handshake: reg_valid sampled high while reg_ready=0 shall produce reg_ready=1 on the next cycle, then reg_ready=0 for at least one cycle (one access per two cycles maximum).
REQ-018 Writes shall take effect on the same edge that raises reg_ready; read data shall be captured on that edge.
REQ-019 Write-only registers (6, 7) shall read 0; writes to DATA_IN shall be ignored.
REQ-020 Bits [31:WIDTH] shall read 0 and shall be ignored on write.
REQ-021 DATA_IN shall equal gpio_in delayed by exactly SYNC_STAGES clk cycles, via a flop chain per bit.
REQ-022 A per-bit edge shall be detected by comparing the last synchroniser stage with a one-cycle-delayed copy of it: rising = new & ~old, falling = ~new & old, selected per bit by IRQ_EDGE.
REQ-023 A detected edge shall set the IRQ_PEND bit on the next edge, regardless of IRQ_EN.
REQ-024 If an edge sets an IRQ_PEND bit in the same cycle that a W1C write clears it, set shall win.
REQ-025 irq shall equal |(IRQ_PEND & IRQ_EN), combinational from registers.
REQ-026 A change to IRQ_EDGE shall not itself generate an edge event.

Reset
REQ-027 While reset=1, the following shall be held at 0: DATA_OUT, IRQ_EN, IRQ_EDGE, IRQ_PEND, all synchroniser and edge flops, reg_ready, reg_rdata, and irq. OEB shall be held at all ones, so all pins are inputs.
REQ-028 Reset asserted mid-access shall abort the access without generating reg_ready; the first access after reset deassertion shall follow REQ-017.
REQ-029 After reset deassertion, no edge event shall be reported until SYNC_STAGES+1 cycles have elapsed.

Configuration
REQ-030 Macro GPIO_BANK_IRQ_EN: when defined, the interrupt logic of REQ-022..REQ-026 shall be present.
REQ-031 When GPIO_BANK_IRQ_EN is undefined, no edge or pending flops shall be built, registers 3..5 shall read 0 and ignore writes, and irq shall be tied to 0.

Verification
REQ-032 Reset, then read OEB with WIDTH=16 -> rdata=0x0000FFFF; gpio_out=0; irq=0.
REQ-033 Write OEB=0x00FF, DATA_OUT=0xA500, then OUT_SET=0x000B and OUT_CLR=0x0500 -> gpio_oeb=0x00FF, gpio_out=0xA00B, and a DATA_OUT read returns 0x0000A00B.
REQ-034 Drive gpio_in=0x1234 -> DATA_IN reads 0x1234 starting exactly SYNC_STAGES cycles after the change; a write of 0xFFFFFFFF to DATA_IN changes nothing.
REQ-035 IRQ_EN=0x0003, IRQ_EDGE=0x0001; drive bit0 0->1 and bit1 1->0 -> IRQ_PEND=0x0003 and irq=1; write IRQ_PEND=0x0001 -> IRQ_PEND=0x0002 and irq=1.
REQ-036 Time a W1C of bit0 on the same cycle as a new bit0 rising edge -> bit0 remains pending.
REQ-037 Build without GPIO_BANK_IRQ_EN and toggle every pin -> irq stays 0, and registers 3..5 read 0.
